util_fifo2avl: RTL and testbench
================================

Name: util_fifo2avl

Overview:
- Read-side counterpart of the Avalon-to-FIFO write utility: drains a 64-bit show-ahead-less FIFO and presents the words as an Avalon-ST source with sop/eop framing.
- Packet reads start on a sync pulse. Each packet is pkt_len words long.
- A small skid buffer with credit accounting hides the FIFO read latency, so dout_ready backpressure never loses data.
- Sits between the TX sample FIFO and the Ethernet framer.

Parameters:
- READ_LATENCY, 1, cycles from fifo_rd_en sampled high to fifo_rd_data valid; legal range 1..3.
- BUF_DEPTH, 4, skid-buffer entries; must be >= READ_LATENCY+2; power of two.

Ports:
- clk  in  1  clock, posedge active
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  block enable
- rd_sync  in  1  packet start request, single-cycle pulse
- pkt_len  in  16  packet length in words, latched on accepted rd_sync
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  64  FIFO read data
- fifo_rd_en  out  1  FIFO read strobe
- dout_ready  in  1  Avalon-ST sink ready
- dout_valid  out  1  Avalon-ST valid
- dout_data  out  64  Avalon-ST data
- dout_sop  out  1  first word of packet, qualified by dout_valid
- dout_eop  out  1  last word of packet, qualified by dout_valid
- busy  out  1  packet in progress (state STREAM or buffer/pipeline non-empty)
- sync_err  out  1  one-cycle pulse when rd_sync is ignored
- underflow  out  1  sticky; set when a read is wanted in STREAM but fifo_empty=1; cleared only by reset

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer empty, counters 0, tag pipeline cleared.
- FSM states and transitions:
  - IDLE: leaves only when enable=1, going to ARMED.
  - ARMED: on rd_sync=1 && pkt_len!=0, latch len, clear remaining=len, go to STREAM.
  - ARMED, rd_sync with pkt_len=0: ignored, sync_err pulse.
  - ARMED, enable=0: go to IDLE.
  - STREAM: issue reads until len reads have been issued, then go to ARMED if enable=1, else IDLE.
  - STREAM, enable deasserted: the current packet completes (no truncation); the exit is to IDLE.
- rd_sync outside ARMED (IDLE or STREAM) is ignored and pulses sync_err. This includes rd_sync in the exact cycle the last read of a packet is issued.
- Read issue: fifo_rd_en = (state==STREAM) && !fifo_empty && (buf_count + inflight) < BUF_DEPTH.
  - fifo_rd_en is combinational from registered state and counts plus fifo_empty.
- inflight:
  - Counts reads issued but not yet captured; range 0..READ_LATENCY.
  - Increments when rd_en is high, decrements on capture. Both in one cycle leaves it unchanged.
- Tag pipeline: a READ_LATENCY-deep shift register carries {valid, sop, eop} alongside each read.
  - sop = first read of the packet; eop = read with remaining==1.
  - A 1-word packet has sop=eop=1.
- Capture: when the tag pipeline output valid=1, fifo_rd_data and its tags are written at buffer wr_ptr.
- Latency: rd_en high in cycle T gives dout_valid high no earlier than T+READ_LATENCY+1 (2 cycles at default).
- Output: dout_valid = buffer non-empty; dout_data/sop/eop = head entry.
  - Pop on dout_valid && dout_ready.
  - Simultaneous capture and pop: count unchanged, both pointers advance.
- Stability: while dout_valid && !dout_ready, dout_data/sop/eop hold stable.
- Credit guarantee: buffer can never overflow. An overflow attempt is a design error; it is flagged by an assertion in simulation only.
- Pointers wrap modulo BUF_DEPTH.
- underflow: set in any STREAM cycle where reads remain and fifo_empty=1. The read simply stalls; no data is dropped or duplicated.
- Words are emitted in FIFO order, with exactly len words per accepted sync.
- busy drops the cycle after the eop word is popped and the FSM is not in STREAM.
- Async reset mid-packet: everything returns to reset values immediately. A partial packet is discarded and no eop is produced.

Test Plan:
- Basic packet: enable=1, pkt_len=4, rd_sync, FIFO holds 0x10..0x13, dout_ready=1.
  - Expect fifo_rd_en 4 cycles.
  - Expect dout_valid 4 consecutive cycles starting 2 cycles after the first rd_en.
  - Expect data 0x10..0x13, sop on 0x10, eop on 0x13.
- Backpressure: same packet, dout_ready toggles 1,0,0,1,...
  - Expect all 4 words in order, with data held stable during ready=0.
  - Expect fifo_rd_en to stop once buf_count+inflight reaches 4.
- Underflow stall: pkt_len=3, FIFO holds 1 word, then 2 more words arrive 5 cycles later.
  - Expect underflow=1 and a read stall.
  - Output still 3 words; sop on the first, eop on the third.
- Sync errors:
  - rd_sync during STREAM: expect a sync_err pulse and no length change.
  - rd_sync with pkt_len=0 in ARMED: expect sync_err and no reads.
- Single-word packets and disable: pkt_len=1, two syncs back-to-back in ARMED.
  - Expect two words, each with sop=eop=1.
  - Then drop enable mid-packet of len 8: expect all 8 words delivered, then state IDLE and busy=0.
- Reset mid-packet: assert rst_n=0 after 2 of 6 words are output.
  - Expect dout_valid=0 and fifo_rd_en=0 immediately, underflow=0, and no further output until a new enable plus sync.

Source files
------------

// File: rtl/util_fifo2avl.sv
`default_nettype none
// ============================================================================
//  Module   : util_fifo2avl
//  Purpose  : Drains a 64-bit FIFO without show-ahead and presents the words
//             as an Avalon-ST source with sop/eop framing. A packet of
//             pkt_len words is read for each accepted rd_sync. A small skid
//             buffer with credit accounting hides the FIFO read latency, so
//             dout_ready backpressure never loses data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    READ_LATENCY  cycles from fifo_rd_en sampled high to fifo_rd_data valid
//                  (1..3)
//    BUF_DEPTH     skid-buffer entries; power of two, >= READ_LATENCY+2
//  Ports
//    clk           clock, rising edge
//    rst_n         asynchronous active-low reset
//    enable        block enable; dropping it mid-packet lets the packet finish
//    rd_sync       packet start request (single-cycle pulse)
//    pkt_len       packet length in words, latched on an accepted rd_sync
//    fifo_empty    FIFO empty flag
//    fifo_rd_data  FIFO read data, READ_LATENCY cycles after fifo_rd_en
//    fifo_rd_en    FIFO read strobe
//    dout_ready    Avalon-ST sink ready
//    dout_valid    Avalon-ST valid
//    dout_data     Avalon-ST data
//    dout_sop      first word of a packet (qualified by dout_valid)
//    dout_eop      last word of a packet (qualified by dout_valid)
//    busy          packet in progress or words still in flight/buffered
//    sync_err      one-cycle pulse when an rd_sync was ignored
//    underflow     sticky: a read was wanted while the FIFO was empty
// ============================================================================
module util_fifo2avl #(
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rd_sync,
    input  logic [15:0] pkt_len,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_rd_data,
    output logic        fifo_rd_en,
    input  logic        dout_ready,
    output logic        dout_valid,
    output logic [63:0] dout_data,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        busy,
    output logic        sync_err,
    output logic        underflow
);

    localparam int                 c_PTR_W = $clog2(BUF_DEPTH);
    localparam int                 c_CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(BUF_DEPTH);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if ((READ_LATENCY < 1) || (READ_LATENCY > 3) ||
            (BUF_DEPTH < READ_LATENCY + 2) ||
            ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_param_err
            $error("util_fifo2avl: illegal READ_LATENCY/BUF_DEPTH combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_len;
    logic [15:0]        r_remaining;       // reads still to be issued
    logic [c_CNT_W-1:0] r_inflight;        // reads issued, not yet captured
    logic [c_CNT_W-1:0] r_buf_count;
    logic [c_CNT_W-1:0] w_credit_used;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_sync_err;
    logic               r_underflow;

    logic               w_accept;
    logic               w_rd_en;
    logic               w_last_rd;
    logic               w_tag_sop;
    logic               w_tag_eop;
    logic               w_capture;
    logic               w_cap_sop;
    logic               w_cap_eop;
    logic               w_pop;

    // Tag pipeline travelling alongside each outstanding read
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_sop;
    logic [READ_LATENCY-1:0] r_tag_eop;

    // Skid buffer storage; emptiness is tracked by r_buf_count, so the
    // data array itself needs no reset.
    logic [63:0]          r_mem_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_mem_sop;
    logic [BUF_DEPTH-1:0] r_mem_eop;

    assign w_accept = (r_state == ST_ARMED) && rd_sync && (pkt_len != 16'd0);

    // Credits: a read is only issued if the buffer is guaranteed to have
    // room for it when it lands, counting reads still in the pipeline.
    assign w_credit_used = r_buf_count + r_inflight;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_last_rd   = 1'b0;

        if ((r_state == ST_STREAM) && !fifo_empty && (w_credit_used < c_DEPTH)) begin
            w_rd_en = 1'b1;
        end
        w_last_rd = w_rd_en && (r_remaining == 16'd1);

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_accept) begin
                    w_state_nxt = ST_STREAM;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // A packet is never truncated; enable only chooses the exit.
                if (w_last_rd) begin
                    w_state_nxt = enable ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Packet length and read accounting
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= 16'd0;
            r_remaining <= 16'd0;
        end else if (w_accept) begin
            r_len       <= pkt_len;
            r_remaining <= pkt_len;
        end else if (w_rd_en) begin
            r_remaining <= r_remaining - 16'd1;
        end
    end

    // First read of the packet sees remaining still equal to the full length.
    assign w_tag_sop = (r_remaining == r_len);
    assign w_tag_eop = (r_remaining == 16'd1);

    // ------------------------------------------------------------------------
    // Tag pipeline: stage READ_LATENCY-1 lines up with fifo_rd_data
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 1) begin : g_tag_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_v   <= '0;
                    r_tag_sop <= '0;
                    r_tag_eop <= '0;
                end else begin
                    r_tag_v   <= w_rd_en;
                    r_tag_sop <= w_tag_sop;
                    r_tag_eop <= w_tag_eop;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_v   <= '0;
                    r_tag_sop <= '0;
                    r_tag_eop <= '0;
                end else begin
                    r_tag_v   <= {r_tag_v[READ_LATENCY-2:0],   w_rd_en};
                    r_tag_sop <= {r_tag_sop[READ_LATENCY-2:0], w_tag_sop};
                    r_tag_eop <= {r_tag_eop[READ_LATENCY-2:0], w_tag_eop};
                end
            end
        end
    endgenerate

    assign w_capture = r_tag_v[READ_LATENCY-1];
    assign w_cap_sop = r_tag_sop[READ_LATENCY-1];
    assign w_cap_eop = r_tag_eop[READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_rd_en, w_capture})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------------
    assign w_pop = dout_valid && dout_ready;

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem_data[r_wr_ptr] <= fifo_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_sop   <= '0;
            r_mem_eop   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_buf_count <= '0;
        end else begin
            if (w_capture) begin
                r_mem_sop[r_wr_ptr] <= w_cap_sop;
                r_mem_eop[r_wr_ptr] <= w_cap_eop;
                r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_buf_count <= r_buf_count + c_CNT_W'(1);
                2'b01:   r_buf_count <= r_buf_count - c_CNT_W'(1);
                default: r_buf_count <= r_buf_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sync_err <= rd_sync && !w_accept;
            // In STREAM at least one read is always outstanding, so an empty
            // FIFO here is always a wanted-but-missing word.
            if ((r_state == ST_STREAM) && fifo_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fifo_rd_en = w_rd_en;
    assign dout_valid = (r_buf_count != '0);
    // Head entry is gated so the bus reads as zero whenever nothing is valid.
    assign dout_data  = dout_valid ? r_mem_data[r_rd_ptr] : 64'd0;
    assign dout_sop   = dout_valid && r_mem_sop[r_rd_ptr];
    assign dout_eop   = dout_valid && r_mem_eop[r_rd_ptr];
    assign busy       = (r_state == ST_STREAM) || (r_buf_count != '0) || (r_inflight != '0);
    assign sync_err   = r_sync_err;
    assign underflow  = r_underflow;

    // The credit scheme must make a capture into a full buffer impossible.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_capture && !w_pop && (r_buf_count == c_DEPTH))
    );

endmodule
`default_nettype wire

// File: tb/tb_util_fifo2avl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_util_fifo2avl
//  Purpose  : Self-checking bench for util_fifo2avl. A FIFO model feeds the
//             DUT; an expected-word queue built from the words the bench
//             pushes and the packet lengths it requests is compared against
//             the Avalon-ST output every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_util_fifo2avl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rd_sync;
    logic [15:0] pkt_len;
    logic        fifo_empty;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        dout_ready;
    logic        dout_valid;
    logic [63:0] dout_data;
    logic        dout_sop;
    logic        dout_eop;
    logic        busy;
    logic        sync_err;
    logic        underflow;

    always #5 clk = ~clk;

    util_fifo2avl #(
        .READ_LATENCY (1),
        .BUF_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rd_sync      (rd_sync),
        .pkt_len      (pkt_len),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .dout_ready   (dout_ready),
        .dout_valid   (dout_valid),
        .dout_data    (dout_data),
        .dout_sop     (dout_sop),
        .dout_eop     (dout_eop),
        .busy         (busy),
        .sync_err     (sync_err),
        .underflow    (underflow)
    );

    // ------------------------------------------------------------------------
    // FIFO model: no show-ahead, one cycle read latency, shares the reset.
    // Words handed over in push_q become visible on the next clock edge.
    // ------------------------------------------------------------------------
    logic [63:0] fifo_q [$];
    logic [63:0] push_q [$];
    int          rd_empty_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            push_q.delete();
            fifo_empty   <= 1'b1;
            fifo_rd_data <= 64'd0;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
                else                    rd_empty_err <= rd_empty_err + 1;
            end
            while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // ------------------------------------------------------------------------
    // Expected output stream and counters
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t exp_q [$];
    int   tests    = 0;
    int   fails    = 0;
    int   rd_cnt   = 0;
    int   serr_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_add(input logic [63:0] d, input logic s, input logic e);
        exp_t x;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        exp_q.push_back(x);
    endtask

    task automatic push_raw(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) push_q.push_back(base + 64'(i));
    endtask

    task automatic exp_pkt(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_add(base + 64'(i), (i == 0), (i == n - 1));
    endtask

    task automatic push_words(input logic [63:0] base, input int n);
        push_raw(base, n);
        exp_pkt(base, n);
    endtask

    // Per-cycle comparison of the output stream, done mid-cycle.
    task automatic sb_compare();
        exp_t e;
        if (rst_n === 1'b1) begin
            if (fifo_rd_en) rd_cnt++;
            if (sync_err)   serr_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_no_unexpected_valid", 64'(dout_valid), 64'd0);
            end else if (dout_valid) begin
                e = exp_q[0];
                chk("sb_data", dout_data, e.data);
                chk("sb_sop", 64'(dout_sop), 64'(e.sop));
                chk("sb_eop", 64'(dout_eop), 64'(e.eop));
                if (dout_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    // One clock: compare on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        sb_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || busy) && (n < max_cyc)) begin
            tick();
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        int r0, s0, n, n_pop;
        int t_rd, t_v, t_vl, n_v;

        rst_n      = 1'b0;
        enable     = 1'b0;
        rd_sync    = 1'b0;
        pkt_len    = 16'd0;
        dout_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_dout_data",  dout_data,       64'd0);
        chk("rst_dout_sop",   64'(dout_sop),   64'd0);
        chk("rst_dout_eop",   64'(dout_eop),   64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_sync_err",   64'(sync_err),   64'd0);
        chk("rst_underflow",  64'(underflow),  64'd0);
        rst_n = 1'b1;
        tick();

        // Basic packet: 4 words 0x10..0x13
        push_words(64'h10, 4);
        tick();
        enable = 1'b1;
        tick();
        r0      = rd_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd4;
        t_rd = -1; t_v = -1; t_vl = -1; n_v = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            rd_sync = 1'b0;
            if (fifo_rd_en && (t_rd < 0)) t_rd = i;
            if (dout_valid) begin
                if (t_v < 0) begin
                    t_v = i;
                    chk("basic_first_data", dout_data, 64'h10);
                    chk("basic_first_sop", 64'(dout_sop), 64'd1);
                end
                n_v++;
                t_vl = i;
            end
        end
        chk("basic_rd_count",     64'(rd_cnt - r0), 64'd4);
        chk("basic_latency",      64'(t_v - t_rd),  64'd2);
        chk("basic_valid_cycles", 64'(n_v),         64'd4);
        chk("basic_valid_contig", 64'(t_vl - t_v),  64'd3);
        chk("basic_underflow",    64'(underflow),   64'd0);
        drain("basic_drain", 20);

        // Backpressure: 8 words, sink stalled first, then 1,0,0,1 pattern
        push_words(64'h20, 8);
        tick();
        dout_ready = 1'b0;
        r0         = rd_cnt;
        rd_sync    = 1'b1;
        pkt_len    = 16'd8;
        tick();
        rd_sync = 1'b0;
        repeat (10) tick();
        chk("bp_credit_stall", 64'(rd_cnt - r0), 64'd4);
        chk("bp_hold_valid",   64'(dout_valid),  64'd1);
        chk("bp_hold_data",    dout_data,        64'h20);
        n = 0;
        while ((exp_q.size() != 0) && (n < 80)) begin
            dout_ready = ((n % 4) == 0) || ((n % 4) == 3);
            tick();
            n++;
        end
        dout_ready = 1'b1;
        drain("bp_drain", 20);
        chk("bp_rd_total", 64'(rd_cnt - r0), 64'd8);

        // Underflow stall: 1 word present, 2 more arrive later
        chk("uf_before", 64'(underflow), 64'd0);
        push_raw(64'h30, 1);
        exp_pkt(64'h30, 3);
        tick();
        r0      = rd_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd3;
        tick();
        rd_sync = 1'b0;
        repeat (5) tick();
        chk("uf_flag",        64'(underflow),   64'd1);
        chk("uf_stall_reads", 64'(rd_cnt - r0), 64'd1);
        chk("uf_busy",        64'(busy),        64'd1);
        push_raw(64'h31, 2);
        drain("uf_drain", 30);
        chk("uf_rd_total", 64'(rd_cnt - r0), 64'd3);
        chk("uf_sticky",   64'(underflow),   64'd1);

        // rd_sync during STREAM: ignored, length unchanged
        push_raw(64'h40, 6);
        exp_pkt(64'h40, 4);
        tick();
        r0      = rd_cnt;
        s0      = serr_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd4;
        tick();
        rd_sync = 1'b0;
        tick();
        chk("stream_busy", 64'(busy), 64'd1);
        rd_sync = 1'b1;
        pkt_len = 16'd9;
        tick();
        rd_sync = 1'b0;
        drain("stream_sync_drain", 30);
        chk("stream_sync_err",  64'(serr_cnt - s0), 64'd1);
        chk("stream_sync_len",  64'(rd_cnt - r0),   64'd4);

        // pkt_len = 0 in ARMED: ignored, no reads although FIFO holds words
        r0      = rd_cnt;
        s0      = serr_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd0;
        tick();
        rd_sync = 1'b0;
        repeat (6) tick();
        chk("len0_sync_err", 64'(serr_cnt - s0), 64'd1);
        chk("len0_no_reads", 64'(rd_cnt - r0),   64'd0);

        // Single-word packets; the middle sync lands on the last-read cycle
        exp_pkt(64'h44, 1);
        exp_pkt(64'h45, 1);
        r0      = rd_cnt;
        s0      = serr_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd1;
        tick();
        tick();
        tick();
        rd_sync = 1'b0;
        drain("single_drain", 20);
        chk("single_rd_count", 64'(rd_cnt - r0),   64'd2);
        chk("single_sync_err", 64'(serr_cnt - s0), 64'd1);

        // Enable dropped mid-packet: packet completes, then IDLE
        push_words(64'h50, 8);
        tick();
        r0      = rd_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd8;
        tick();
        rd_sync = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        drain("dis_drain", 60);
        chk("dis_rd_count", 64'(rd_cnt - r0), 64'd8);
        s0      = serr_cnt;
        rd_sync = 1'b1;
        pkt_len = 16'd4;
        tick();
        rd_sync = 1'b0;
        tick();
        tick();
        chk("dis_idle_sync_err", 64'(serr_cnt - s0), 64'd1);
        chk("dis_idle_no_reads", 64'(rd_cnt - r0),   64'd8);

        // Asynchronous reset after 2 of 6 words
        enable = 1'b1;
        tick();
        push_words(64'h60, 6);
        tick();
        rd_sync = 1'b1;
        pkt_len = 16'd6;
        tick();
        rd_sync = 1'b0;
        n_pop = 0;
        n     = 0;
        while ((n_pop < 2) && (n < 20)) begin
            if (dout_valid && dout_ready) n_pop++;
            tick();
            n++;
        end
        chk("rstmid_words_out", 64'(n_pop), 64'd2);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("rstmid_dout_valid", 64'(dout_valid), 64'd0);
        chk("rstmid_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rstmid_underflow",  64'(underflow),  64'd0);
        chk("rstmid_busy",       64'(busy),       64'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        r0    = rd_cnt;
        repeat (6) tick();
        chk("rstmid_quiet_reads", 64'(rd_cnt - r0), 64'd0);
        chk("rstmid_quiet_valid", 64'(dout_valid),  64'd0);

        // Recovery after reset
        enable = 1'b1;
        tick();
        push_words(64'h70, 3);
        tick();
        rd_sync = 1'b1;
        pkt_len = 16'd3;
        tick();
        rd_sync = 1'b0;
        drain("recover_drain", 30);
        chk("recover_underflow", 64'(underflow), 64'd0);
        chk("fifo_read_while_empty", 64'(rd_empty_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
